// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor counter type and saturating helpers
// Exports: ctr_t (SNT/WNT/WT/ST), CTR_RESET (WNT), ctr_inc, ctr_dec.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Saturate at ST instead of wrapping to SNT.
  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  // Saturate at SNT instead of wrapping to ST.
  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pht_predictor_if.sv
// rtl/pht_predictor_if.sv - lookup/prediction/update bundle of the PHT predictor
// master (branch unit): drives lookup_valid, index, history, do_update,
//   last_taken, flush; sees lookup_ready, pred_valid, pred_taken, underflow.
// slave (predictor): the mirror image.
interface pht_predictor_if #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 4
);
  logic              lookup_valid;
  logic              lookup_ready;
  logic [IWIDTH-1:0] index;
  logic [HWIDTH-1:0] history;
  logic              pred_valid;
  logic              pred_taken;
  logic              do_update;
  logic              last_taken;
  logic              flush;
  logic              underflow;

  modport master (
    output lookup_valid, index, history, do_update, last_taken, flush,
    input  lookup_ready, pred_valid, pred_taken, underflow
  );

  modport slave (
    input  lookup_valid, index, history, do_update, last_taken, flush,
    output lookup_ready, pred_valid, pred_taken, underflow
  );
endinterface

// File: rtl/pht_queue.sv
// rtl/pht_queue.sv - pending-prediction FIFO with explicit occupancy count
// Ports: clk, resetn (async active-low); push/push_data write the tail;
//   pop advances the head, pop_data shows the head; clear empties the queue
//   and overrides push/pop; count/full/empty report occupancy.
// The caller must not push when full or pop when empty.
module pht_queue #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally modulo DEPTH;
  // the separate count is what distinguishes full from empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pht_predictor.sv
// rtl/pht_predictor.sv - 2-bit saturating-counter pattern history table
// Ports: clk; resetn (async active-low); en (global enable, low freezes
//   state); bus (pht_predictor_if.slave): lookup_valid/lookup_ready/index/
//   history request a prediction, pred_valid/pred_taken return it one cycle
//   later, do_update/last_taken train the oldest pending branch, flush
//   squashes all pending branches, underflow flags an update with nothing
//   pending (sticky until reset).
module pht_predictor
  import bp_pkg::*;
#(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 4,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  pht_predictor_if.slave    bus
);

  localparam int AW   = IWIDTH + HWIDTH;
  localparam int NENT = 1 << AW;
  localparam int CW   = $clog2(QDEPTH) + 1;

  ctr_t            tbl [NENT];
  logic [AW-1:0]   lookup_addr;
  logic [AW-1:0]   head_addr;
  ctr_t            lookup_ctr;
  ctr_t            head_ctr;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count_unused;
  logic            accept;
  logic            upd_ok;
  logic            upd_empty;
  logic            do_flush;

  assign lookup_addr = {bus.index, bus.history};

  // Ready comes from the registered count only, so a slot freed by this
  // cycle's update becomes visible on the next cycle.
  assign bus.lookup_ready = en && !q_full;

  assign do_flush  = en && bus.flush;
  // A lookup arriving together with a flush is squashed with the rest.
  assign accept    = en && bus.lookup_valid && !q_full && !bus.flush;
  assign upd_ok    = en && bus.do_update && !q_empty;
  assign upd_empty = en && bus.do_update && q_empty;

  pht_queue #(
    .WIDTH (AW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (lookup_addr),
    .pop       (upd_ok),
    .pop_data  (head_addr),
    .clear     (do_flush),
    .count     (q_count_unused),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Both reads come from the pre-edge table, so a lookup that hits the
  // address being trained this cycle sees the old counter.
  assign lookup_ctr = tbl[lookup_addr];
  assign head_ctr   = tbl[head_addr];

  // Training happens even on a flush cycle: the update is applied before
  // the queue is emptied.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NENT; i++) tbl[i] <= CTR_RESET;
    end else if (upd_ok) begin
      tbl[head_addr] <= bus.last_taken ? ctr_inc(head_ctr) : ctr_dec(head_ctr);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      bus.pred_valid <= accept;
      if (accept)    bus.pred_taken <= lookup_ctr[1];
      if (upd_empty) bus.underflow  <= 1'b1;
    end
  end

endmodule
